// File: rtl/plcp_framer_if.sv
// Byte-stream input and serial bit-stream output of the PLCP framer.
// The master side is the framer itself; the slave side is its environment.
interface plcp_framer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       out_ready;

  modport master (
    input  byte_in, byte_valid, out_ready,
    output byte_ready, bit_out, bit_valid
  );

  modport slave (
    output byte_in, byte_valid, out_ready,
    input  byte_ready, bit_out, bit_valid
  );
endinterface

// File: rtl/plcp_framer.sv
// 802.11b long-preamble PLCP framer: SYNC, SFD, header, CRC-16 and PSDU,
// serialised one bit per accepted cycle towards the scrambler.
module plcp_framer #(
  parameter int LEN_W     = 12,
  parameter int SYNC_BITS = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       signal_in,
  input  logic [7:0]       service_in,
  input  logic [15:0]      length_in,
  input  logic [LEN_W-1:0] payload_len,
  plcp_framer_if.master    bus,
  output logic             scr_reset,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [15:0] SFD_WORD = 16'hF3A0;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SYNC, S_SFD, S_HDR, S_CRC, S_PAY
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       bit_cnt_reg;
  logic [7:0]       signal_reg, service_reg;
  logic [15:0]      length_reg;
  logic [LEN_W-1:0] plen_reg;
  logic [15:0]      crc_reg;
  logic [7:0]       hold_reg, shift_reg;
  logic             hold_full_reg;
  logic [LEN_W-1:0] fetched_reg, loaded_reg;
  logic             done_reg, underrun_reg;

  logic             tx_bit, tx_valid, byte_rdy;
  logic             accept, byte_take;
  logic             last_bit, load_shift, done_next, underrun_next;
  logic [31:0]      hdr_word;
  logic             crc_fb;
  logic [15:0]      crc_step;

  assign hdr_word  = {length_reg, service_reg, signal_reg};
  assign accept    = tx_valid & bus.out_ready;
  assign byte_rdy  = busy & ~hold_full_reg & (fetched_reg < plen_reg);
  assign byte_take = bus.byte_valid & byte_rdy;
  assign crc_fb    = tx_bit ^ crc_reg[15];
  assign crc_step  = {crc_reg[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // A new shift byte is needed at the end of CRC and at every byte boundary
  // in PAY; an empty hold register at that moment aborts the frame.
  always_comb begin
    state_next    = state_reg;
    last_bit      = 1'b0;
    load_shift    = 1'b0;
    done_next     = 1'b0;
    underrun_next = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_INIT;
      S_INIT: state_next = S_SYNC;
      S_SYNC: begin
        last_bit = (bit_cnt_reg == 8'(SYNC_BITS - 1));
        if (accept && last_bit) state_next = S_SFD;
      end
      S_SFD: begin
        last_bit = (bit_cnt_reg == 8'd15);
        if (accept && last_bit) state_next = S_HDR;
      end
      S_HDR: begin
        last_bit = (bit_cnt_reg == 8'd31);
        if (accept && last_bit) state_next = S_CRC;
      end
      S_CRC: begin
        last_bit = (bit_cnt_reg == 8'd15);
        if (accept && last_bit) begin
          if (plen_reg == '0) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else if (!hold_full_reg) begin
            state_next    = S_IDLE;
            underrun_next = 1'b1;
          end else begin
            state_next = S_PAY;
            load_shift = 1'b1;
          end
        end
      end
      S_PAY: begin
        last_bit = (bit_cnt_reg == 8'd7);
        if (accept && last_bit) begin
          if (loaded_reg == plen_reg) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else if (!hold_full_reg) begin
            state_next    = S_IDLE;
            underrun_next = 1'b1;
          end else begin
            load_shift = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit    = 1'b0;
    tx_valid  = 1'b0;
    scr_reset = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      S_INIT: begin
        scr_reset = 1'b1;
        busy      = 1'b1;
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = 1'b1;
      end
      S_SFD: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = SFD_WORD[bit_cnt_reg[3:0]];
      end
      S_HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = hdr_word[bit_cnt_reg[4:0]];
      end
      S_CRC: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = ~crc_reg[4'd15 - bit_cnt_reg[3:0]];
      end
      S_PAY: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = shift_reg[0];
      end
      default: ;
    endcase
  end

  assign bus.bit_out    = tx_bit;
  assign bus.bit_valid  = tx_valid;
  assign bus.byte_ready = byte_rdy;
  assign done           = done_reg;
  assign underrun       = underrun_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_reg   <= '0;
      signal_reg    <= '0;
      service_reg   <= '0;
      length_reg    <= '0;
      plen_reg      <= '0;
      crc_reg       <= '0;
      hold_reg      <= '0;
      shift_reg     <= '0;
      hold_full_reg <= 1'b0;
      fetched_reg   <= '0;
      loaded_reg    <= '0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      done_reg     <= done_next;
      underrun_reg <= underrun_next;
      if (state_reg == S_IDLE) begin
        if (start) begin
          signal_reg    <= signal_in;
          service_reg   <= service_in;
          length_reg    <= length_in;
          plen_reg      <= payload_len;
          crc_reg       <= 16'hFFFF;
          bit_cnt_reg   <= '0;
          fetched_reg   <= '0;
          loaded_reg    <= '0;
          hold_full_reg <= 1'b0;
        end
      end else begin
        if (accept) begin
          bit_cnt_reg <= last_bit ? 8'd0 : bit_cnt_reg + 8'd1;
          if (state_reg == S_HDR) crc_reg <= crc_step;
          if (state_reg == S_PAY) shift_reg <= {1'b0, shift_reg[7:1]};
        end
        // load_shift and byte_take never coincide: one needs hold full, the other empty
        if (load_shift) begin
          shift_reg     <= hold_reg;
          hold_full_reg <= 1'b0;
          loaded_reg    <= loaded_reg + LEN_W'(1);
        end
        if (byte_take) begin
          hold_reg      <= bus.byte_in;
          hold_full_reg <= 1'b1;
          fetched_reg   <= fetched_reg + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_plcp_framer.sv
// Randomised scoreboard bench for plcp_framer: a frame-level model queues the
// expected bit stream at start, a negedge monitor pops and compares every accepted bit.
module tb_plcp_framer;
  localparam int LEN_W     = 12;
  localparam int SYNC_BITS = 128;
  localparam int TMO       = 20000;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       signal_in = '0, service_in = '0;
  logic [15:0]      length_in = '0;
  logic [LEN_W-1:0] payload_len = '0;
  logic             scr_reset, busy, done, underrun;

  plcp_framer_if bus();

  plcp_framer #(.LEN_W(LEN_W), .SYNC_BITS(SYNC_BITS)) dut (
    .clock(clock), .reset(reset), .start(start),
    .signal_in(signal_in), .service_in(service_in), .length_in(length_in),
    .payload_len(payload_len), .bus(bus),
    .scr_reset(scr_reset), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  bit exp_q[$];
  logic [7:0] src_q[$];
  int cyc = 0, acc_cnt = 0, hs_cnt = 0, scr_cnt = 0, done_cnt = 0, und_cnt = 0;
  int init_cyc = 0, done_cyc = 0, und_cyc = 0, last_acc_cyc = 0;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0, prev_bit = 1'b0, exp_bit = 1'b0, drv_took = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (scr_reset) begin scr_cnt++; init_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; check("busy_at_done", busy, 0); end
      if (underrun) begin und_cnt++; und_cyc = cyc; check("busy_at_underrun", busy, 0); end
      if (prev_stall && bus.bit_valid) check("stall_hold", bus.bit_out, prev_bit);
      if (bus.bit_valid && bus.out_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_bit: got bit %0b expected none", bus.bit_out);
        end else begin
          exp_bit = exp_q.pop_front();
          check($sformatf("bit%0d", acc_cnt), bus.bit_out, exp_bit);
        end
      end
      prev_stall = bus.bit_valid && !bus.out_ready;
      prev_bit   = bus.bit_out;
    end
  end

  // byte source and downstream ready driver
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.out_ready  = 1'b1;
    forever begin
      @(negedge clock);
      drv_took = bus.byte_valid && bus.byte_ready && !reset;
      @(posedge clock);
      #1;
      if (drv_took) begin
        hs_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      bus.byte_valid = (src_q.size() > 0);
      bus.byte_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
      bus.out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // frame-level reference: returns how many payload bytes the source can supply
  task automatic push_expected(input logic [7:0] s, input logic [7:0] sv,
                               input logic [15:0] l, input int plen, output int avail);
    logic [15:0] sfd;
    logic [31:0] hdr;
    logic [15:0] c;
    logic        fb;
    logic [7:0]  b;
    sfd = 16'hF3A0;
    hdr = {l, sv, s};
    for (int i = 0; i < SYNC_BITS; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(sfd[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(hdr[i]);
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = hdr[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
    avail = (src_q.size() < plen) ? src_q.size() : plen;
    for (int k = 0; k < avail; k++) begin
      b = src_q[k];
      for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] s, input logic [7:0] sv,
                           input logic [15:0] l, input int plen, input bit rnd,
                           input bit hdr_start, input bit exp_done, input int init_to_done);
    int avail, a0, h0, s0, d0, u0, tmo, ev_cyc;
    rand_ready = rnd;
    push_expected(s, sv, l, plen, avail);
    a0 = acc_cnt; h0 = hs_cnt; s0 = scr_cnt; d0 = done_cnt; u0 = und_cnt;
    @(posedge clock); #1;
    signal_in = s; service_in = sv; length_in = l; payload_len = LEN_W'(plen);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    signal_in = 8'($urandom); service_in = 8'($urandom);
    length_in = 16'($urandom); payload_len = LEN_W'($urandom);
    if (hdr_start) begin
      tmo = 0;
      while (acc_cnt - a0 < SYNC_BITS + 22 && tmo < TMO) begin @(posedge clock); tmo++; end
      @(posedge clock); #1;
      signal_in = ~s; service_in = ~sv; length_in = ~l; payload_len = LEN_W'(plen + 5);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_after_ignored_start", busy, 1);
    end
    tmo = 0;
    while (done_cnt == d0 && und_cnt == u0 && tmo < TMO) begin @(posedge clock); tmo++; end
    if (tmo >= TMO) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no done/underrun after %0d cycles expected one", name, tmo);
    end
    @(negedge clock);
    #1;
    check({name, "_done"}, done_cnt - d0, exp_done ? 1 : 0);
    check({name, "_underrun"}, und_cnt - u0, exp_done ? 0 : 1);
    check({name, "_scr_reset"}, scr_cnt - s0, 1);
    check({name, "_bytes"}, hs_cnt - h0, avail);
    check({name, "_bits"}, acc_cnt - a0, SYNC_BITS + 64 + 8 * avail);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy_end"}, busy, 0);
    ev_cyc = exp_done ? done_cyc : und_cyc;
    check({name, "_event_timing"}, ev_cyc, last_acc_cyc + 1);
    if (init_to_done > 0) check({name, "_init_to_done"}, done_cyc - init_cyc, init_to_done);
    $display("frame %s plen=%0d bits=%0d bytes=%0d done=%0d underrun=%0d", name, plen,
             acc_cnt - a0, hs_cnt - h0, done_cnt - d0, und_cnt - u0);
    exp_q.delete();
    src_q.delete();
  endtask

  initial begin
    int a0, tmo, avail, n;
    #2 reset = 1'b1;
    #1;
    check("reset_outputs", {bus.bit_valid, bus.bit_out, bus.byte_ready, scr_reset, busy, done, underrun}, 0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    run_frame("hdr_only", 8'h0A, 8'h00, 16'h0010, 0, 1'b0, 1'b0, 1'b1, 193);

    src_q = '{8'h01, 8'h80, 8'hFF};
    run_frame("pay3", 8'h0A, 8'h00, 16'h0010, 3, 1'b0, 1'b0, 1'b1, 217);

    src_q = '{8'h01, 8'h80, 8'hFF};
    run_frame("pay3_rand_ready", 8'h0A, 8'h00, 16'h0010, 3, 1'b1, 1'b0, 1'b1, 0);

    src_q = '{8'h5A};
    run_frame("underrun", 8'h14, 8'h04, 16'h0123, 2, 1'b0, 1'b0, 1'b0, 0);

    // reset in the middle of SFD
    rand_ready = 1'b0;
    src_q = '{8'hC3, 8'h3C};
    push_expected(8'h37, 8'h00, 16'h0040, 2, avail);
    a0 = acc_cnt;
    @(posedge clock); #1;
    signal_in = 8'h37; service_in = 8'h00; length_in = 16'h0040; payload_len = 2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tmo = 0;
    while (acc_cnt - a0 < SYNC_BITS + 5 && tmo < TMO) begin @(posedge clock); tmo++; end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midframe_reset_outputs", {bus.bit_valid, bus.bit_out, bus.byte_ready, scr_reset, busy, done, underrun}, 0);
    exp_q.delete();
    src_q.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    $display("frame sfd_reset aborted after %0d bits", acc_cnt - a0);

    src_q = '{8'($urandom), 8'($urandom)};
    run_frame("after_reset", 8'h6E, 8'h80, 16'h0A5C, 2, 1'b0, 1'b0, 1'b1, 209);

    src_q = '{8'($urandom)};
    run_frame("start_in_hdr", 8'($urandom), 8'($urandom), 16'($urandom), 1, 1'b0, 1'b1, 1'b1, 201);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) src_q.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), 8'($urandom), 8'($urandom), 16'($urandom), n,
                1'($urandom_range(0, 1)), 1'b0, 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/plcp_framer.md
Name: plcp_framer

Overview:
- Builds the 802.11b long-preamble PLCP frame and serialises it one bit per accepted cycle into the scrambler's bit_in / enable inputs.
- Sits directly upstream of the scrambler. It also issues the scrambler's per-frame reset.
- Emits SYNC, SFD, the PLCP header (SIGNAL, SERVICE, LENGTH), CRC-16, then the PSDU bytes pulled from a byte-stream handshake.

Parameters:
LEN_W  12  width of the payload byte count (maximum PSDU 4095 bytes)
SYNC_BITS  128  number of SYNC bits (all ones)

Ports:
clock  input  1  design clock
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; latches the header fields and begins a frame (ignored while busy)
signal_in  input  8  SIGNAL field
service_in  input  8  SERVICE field
length_in  input  16  LENGTH field (microseconds; carried in the header only)
payload_len  input  LEN_W  PSDU byte count, latched at start
byte_in  input  8  payload byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  framer accepts byte_in this cycle when byte_valid is high
out_ready  input  1  downstream accepts bit_out this cycle
bit_out  output  1  serial frame bit, drives scrambler bit_in
bit_valid  output  1  bit_out valid; bit_valid & out_ready drives scrambler enable
scr_reset  output  1  one-cycle pulse to the scrambler reset, asserted the cycle after start is accepted
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse after the last bit is accepted
underrun  output  1  one-cycle pulse when the frame aborts for lack of payload data

Behaviour:
- Reset (asynchronous): state IDLE; all counters, the hold register and all outputs are 0.
- States: IDLE -> INIT -> SYNC -> SFD -> HDR -> CRC -> PAY -> IDLE.
- IDLE
  - A start pulse latches signal_in, service_in, length_in and payload_len.
  - The CRC register is preset to 16'hFFFF. Next state is INIT.
- INIT
  - Lasts one cycle. scr_reset = 1, bit_valid = 0, busy = 1.
- Bit transfer
  - In SYNC through PAY, bit_valid = 1.
  - A bit advances only on bit_valid & out_ready. bit_out holds steady while out_ready is low.
- SYNC: SYNC_BITS ones.
- SFD: 16'hF3A0, LSB first.
- HDR
  - 32 bits: SIGNAL, SERVICE, LENGTH[15:0], each field LSB first.
  - Every accepted HDR bit updates the CRC-16: polynomial x^16+x^12+x^5+1, fb = bit ^ crc[15], crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0).
- CRC: the ones-complement of the CRC register, sent crc[15] first, 16 bits.
- Transition out of CRC: if payload_len == 0, go to IDLE with done pulsed; otherwise go to PAY.
- PAY: each byte is sent LSB first, 8*payload_len bits in total.
- Total accepted bits per frame = SYNC_BITS + 64 + 8*payload_len.
- Byte prefetch:
  - The framer has a one-byte hold register plus a shift register.
  - byte_ready = busy & !hold_full & (bytes_fetched < payload_len). Fetching may start during SYNC.
  - A byte is taken on byte_valid & byte_ready.
  - The shift register loads from the hold register in the same cycle that the previous byte's bit 7 is accepted (or on entry to PAY).
- Underrun: a shift load is required, more bytes remain, and hold is empty.
  - underrun pulses; go to IDLE; bit_valid drops the next cycle; done is not pulsed.
- done: pulses one cycle after the final bit is accepted; busy falls in that same cycle.
- start while busy is ignored.
- A simultaneous start and done cycle is impossible, because busy blocks start until IDLE.
- Reset mid-frame aborts immediately. No done or underrun pulse is issued.
- Counter width: the bit counter is 8 bits (covers SYNC_BITS up to 255). The byte counters are LEN_W bits.

Test Plan:
- Frame with start, signal 0x0A, service 0x00, length 0x0010, payload_len 0:
  - scr_reset high exactly one cycle, then 128 ones.
  - SFD bits 0,0,0,0,0,1,0,1,1,1,0,0,1,1,1,1.
  - 32 header bits LSB first; CRC bits match the golden CRC-16 model.
  - done 193 cycles after INIT with out_ready held high.
- payload_len 3, bytes 0x01, 0x80, 0xFF always valid:
  - payload bits 10000000 00000001 11111111.
  - exactly 3 byte handshakes; 216 bits total.
- out_ready toggled randomly 50%: the accepted bit stream is identical to the previous test; bit_out stays stable while out_ready is low.
- payload_len 2, second byte withheld: underrun pulses exactly once when byte 0's bit 7 is accepted; busy returns to 0; no done.
- reset asserted mid-SFD: all outputs 0 asynchronously. A following start produces a complete, correct frame.
- start pulsed during the HDR state: no effect on the in-progress frame; the latched fields are unchanged.
